tc_operand_collector: RTL and testbench

Operand staging block in front of the tensor-core matrix multiply-add datapath. Accepts A, B and C operand rows one beat at a time over a narrow valid/ready stream from the register-file read side and assembles them into full-width matrices. Issues one complete matrix transaction, with its control tag, over the wide valid/ready interface that the `mm_mul_add` input port consumes. It is the initiator end of that input handshake.

---
 rtl/tc_operand_collector_pkg.sv | 46 ++++
 rtl/tc_operand_collector.sv | 158 +++++++++++++++
 tb/tb_tc_operand_collector.sv | 245 ++++++++++++++++++++++++
 3 files changed

// File: rtl/tc_operand_collector_pkg.sv
// Shared tensor-core operand-collector definitions: shape defaults, row-width
// derivation, beat-count constants and the collector FSM state encoding.
package tc_operand_collector_pkg;

  localparam int DEF_SHAPE_M          = 8;
  localparam int DEF_SHAPE_N          = 8;
  localparam int DEF_SHAPE_K          = 8;
  localparam int DEF_ELEMENT_WIDTH_AB = 9;
  localparam int DEF_ELEMENT_WIDTH_C  = 22;
  localparam int DEF_DEPTH_WARP       = 4;

  // A narrow beat must carry the wider of an A/B row and a C row.
  function automatic int calc_row_w(input int n, input int k, input int wab, input int wc);
    int ab_w;
    int c_w;
    ab_w = n * wab;
    c_w  = k * wc;
    if (ab_w > c_w) begin
      return ab_w;
    end else begin
      return c_w;
    end
  endfunction

  function automatic int calc_cnt_w(input int m, input int k);
    int mx;
    mx = (m > k) ? m : k;
    if (mx > 1) begin
      return $clog2(mx);
    end else begin
      return 1;
    end
  endfunction

  localparam int DEF_ROW_W = calc_row_w(DEF_SHAPE_N, DEF_SHAPE_K,
                                        DEF_ELEMENT_WIDTH_AB, DEF_ELEMENT_WIDTH_C);
  localparam int NUM_BEATS = 2 * DEF_SHAPE_M + DEF_SHAPE_K;

  typedef enum logic [1:0] {
    LOAD_A = 2'd0,
    LOAD_B = 2'd1,
    LOAD_C = 2'd2,
    ISSUE  = 2'd3
  } oc_state_e;

endpackage

// File: rtl/tc_operand_collector.sv
// Collects A, B and C operand rows from a narrow beat stream and issues one
// complete matrix transaction with its control tag to the multiply-add input.
module tc_operand_collector
  import tc_operand_collector_pkg::*;
#(
  parameter int SHAPE_M          = DEF_SHAPE_M,
  parameter int SHAPE_N          = DEF_SHAPE_N,
  parameter int SHAPE_K          = DEF_SHAPE_K,
  parameter int ELEMENT_WIDTH_AB = DEF_ELEMENT_WIDTH_AB,
  parameter int ELEMENT_WIDTH_C  = DEF_ELEMENT_WIDTH_C,
  parameter int DEPTH_WARP       = DEF_DEPTH_WARP,
  localparam int ROW_W = calc_row_w(SHAPE_N, SHAPE_K, ELEMENT_WIDTH_AB, ELEMENT_WIDTH_C)
) (
  input  logic                                           clk,
  input  logic                                           rst_n,
  input  logic                                           row_valid_i,
  output logic                                           row_ready_o,
  input  logic [ROW_W-1:0]                               row_data_i,
  input  logic [2:0]                                     rm_i,
  input  logic [7:0]                                     ctrl_reg_idxw_i,
  input  logic [DEPTH_WARP-1:0]                          ctrl_warpid_i,
  input  logic                                           flush_i,
  output logic [SHAPE_M*SHAPE_N*ELEMENT_WIDTH_AB-1:0]    a_o,
  output logic [SHAPE_N*SHAPE_K*ELEMENT_WIDTH_AB-1:0]    b_o,
  output logic [SHAPE_M*SHAPE_K*ELEMENT_WIDTH_C-1:0]     c_o,
  output logic [2:0]                                     rm_o,
  output logic [7:0]                                     ctrl_reg_idxw_o,
  output logic [DEPTH_WARP-1:0]                          ctrl_warpid_o,
  output logic                                           out_valid_o,
  input  logic                                           out_ready_i
);

  localparam int AB_ROW_W = SHAPE_N * ELEMENT_WIDTH_AB;
  localparam int C_ROW_W  = SHAPE_K * ELEMENT_WIDTH_C;
  localparam int CNT_W    = calc_cnt_w(SHAPE_M, SHAPE_K);
  localparam logic [CNT_W-1:0] LAST_M = CNT_W'(SHAPE_M - 1);
  localparam logic [CNT_W-1:0] LAST_K = CNT_W'(SHAPE_K - 1);

  oc_state_e                                   state_r;
  logic [CNT_W-1:0]                            beat_cnt_r;
  logic                                        out_valid_r;
  logic [SHAPE_M*SHAPE_N*ELEMENT_WIDTH_AB-1:0] a_r;
  logic [SHAPE_N*SHAPE_K*ELEMENT_WIDTH_AB-1:0] b_r;
  logic [SHAPE_M*SHAPE_K*ELEMENT_WIDTH_C-1:0]  c_r;
  logic [2:0]                                  rm_r;
  logic [7:0]                                  idxw_r;
  logic [DEPTH_WARP-1:0]                       warpid_r;

  logic beat_take_s;
  logic last_beat_s;
  logic ctrl_take_s;

  // Beat acceptance qualifiers; flush wins over a same-cycle beat.
  always_comb begin
    beat_take_s = 1'b0;
    last_beat_s = 1'b0;
    ctrl_take_s = 1'b0;
    if (state_r != ISSUE) begin
      beat_take_s = row_valid_i & ~flush_i;
    end else begin
      beat_take_s = 1'b0;
    end
    case (state_r)
      LOAD_A:  last_beat_s = (beat_cnt_r == LAST_M);
      LOAD_B:  last_beat_s = (beat_cnt_r == LAST_K);
      LOAD_C:  last_beat_s = (beat_cnt_r == LAST_M);
      default: last_beat_s = 1'b0;
    endcase
    if ((state_r == LOAD_A) && (beat_cnt_r == {CNT_W{1'b0}})) begin
      ctrl_take_s = beat_take_s;
    end else begin
      ctrl_take_s = 1'b0;
    end
  end

  // Collector FSM with beat counter and registered issue valid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= LOAD_A;
      beat_cnt_r  <= {CNT_W{1'b0}};
      out_valid_r <= 1'b0;
    end else begin
      case (state_r)
        LOAD_A, LOAD_B, LOAD_C: begin
          if (flush_i) begin
            state_r    <= LOAD_A;
            beat_cnt_r <= {CNT_W{1'b0}};
          end else if (row_valid_i) begin
            if (last_beat_s) begin
              beat_cnt_r <= {CNT_W{1'b0}};
              case (state_r)
                LOAD_A:  state_r <= LOAD_B;
                LOAD_B:  state_r <= LOAD_C;
                default: begin
                  state_r     <= ISSUE;
                  out_valid_r <= 1'b1;
                end
              endcase
            end else begin
              beat_cnt_r <= beat_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
            end
          end
        end
        ISSUE: begin
          if (out_ready_i) begin
            state_r     <= LOAD_A;
            beat_cnt_r  <= {CNT_W{1'b0}};
            out_valid_r <= 1'b0;
          end
        end
        default: begin
          state_r     <= LOAD_A;
          beat_cnt_r  <= {CNT_W{1'b0}};
          out_valid_r <= 1'b0;
        end
      endcase
    end
  end

  // Operand row placement; stale rows are left in place until overwritten.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_r <= '0;
      b_r <= '0;
      c_r <= '0;
    end else if (beat_take_s) begin
      case (state_r)
        LOAD_A:  a_r[int'(beat_cnt_r)*AB_ROW_W +: AB_ROW_W] <= row_data_i[AB_ROW_W-1:0];
        LOAD_B:  b_r[int'(beat_cnt_r)*AB_ROW_W +: AB_ROW_W] <= row_data_i[AB_ROW_W-1:0];
        LOAD_C:  c_r[int'(beat_cnt_r)*C_ROW_W +: C_ROW_W]   <= row_data_i[C_ROW_W-1:0];
        default: a_r <= a_r;
      endcase
    end
  end

  // Control tag captured with the first A row only.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rm_r     <= 3'd0;
      idxw_r   <= 8'd0;
      warpid_r <= {DEPTH_WARP{1'b0}};
    end else if (ctrl_take_s) begin
      rm_r     <= rm_i;
      idxw_r   <= ctrl_reg_idxw_i;
      warpid_r <= ctrl_warpid_i;
    end
  end

  assign row_ready_o     = (state_r != ISSUE);
  assign out_valid_o     = out_valid_r;
  assign a_o             = a_r;
  assign b_o             = b_r;
  assign c_o             = c_r;
  assign rm_o            = rm_r;
  assign ctrl_reg_idxw_o = idxw_r;
  assign ctrl_warpid_o   = warpid_r;

endmodule

// File: tb/tb_tc_operand_collector.sv
// Directed bench for tc_operand_collector: placement, control capture, issue
// hold, flush, valid gaps, resets and back-to-back throughput.
module tb_tc_operand_collector;
  import tc_operand_collector_pkg::*;

  localparam int M   = 8;
  localparam int N   = 8;
  localparam int K   = 8;
  localparam int WAB = 9;
  localparam int WC  = 22;
  localparam int DW  = 4;
  localparam int RW  = DEF_ROW_W;
  localparam int NB  = 2 * M + K;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              row_valid_i;
  logic              row_ready_o;
  logic [RW-1:0]     row_data_i;
  logic [2:0]        rm_i;
  logic [7:0]        ctrl_reg_idxw_i;
  logic [DW-1:0]     ctrl_warpid_i;
  logic              flush_i;
  logic [M*N*WAB-1:0] a_o;
  logic [N*K*WAB-1:0] b_o;
  logic [M*K*WC-1:0]  c_o;
  logic [2:0]        rm_o;
  logic [7:0]        ctrl_reg_idxw_o;
  logic [DW-1:0]     ctrl_warpid_o;
  logic              out_valid_o;
  logic              out_ready_i;

  logic [M*N*WAB-1:0] exp_a;
  logic [N*K*WAB-1:0] exp_b;
  logic [M*K*WC-1:0]  exp_c;
  logic [RW-1:0]      beats [NB];

  int n_pass  = 0;
  int n_total = 0;
  int cyc     = 0;
  int rises[$];
  logic ov_prev = 1'b0;
  int first;

  tc_operand_collector dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .row_valid_i     (row_valid_i),
    .row_ready_o     (row_ready_o),
    .row_data_i      (row_data_i),
    .rm_i            (rm_i),
    .ctrl_reg_idxw_i (ctrl_reg_idxw_i),
    .ctrl_warpid_i   (ctrl_warpid_i),
    .flush_i         (flush_i),
    .a_o             (a_o),
    .b_o             (b_o),
    .c_o             (c_o),
    .rm_o            (rm_o),
    .ctrl_reg_idxw_o (ctrl_reg_idxw_o),
    .ctrl_warpid_o   (ctrl_warpid_o),
    .out_valid_o     (out_valid_o),
    .out_ready_i     (out_ready_i)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (out_valid_o && !ov_prev) rises.push_back(cyc);
    ov_prev = out_valid_o;
  end

  function automatic int last_rise();
    if (rises.size() == 0) return -1000;
    return rises[rises.size()-1];
  endfunction

  task automatic check(input string tag, input logic [RW-1:0] obs, input logic [RW-1:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Element value = (flat index + base) mod 2^W; beats sliced from the expected matrices.
  task automatic build(input int base);
    for (int e = 0; e < M*N; e++) exp_a[e*WAB +: WAB] = WAB'(e + base);
    for (int e = 0; e < N*K; e++) exp_b[e*WAB +: WAB] = WAB'(e + base);
    for (int e = 0; e < M*K; e++) exp_c[e*WC +: WC]   = WC'(e + base);
    for (int r = 0; r < M; r++) beats[r]     = {{(RW-N*WAB){1'b1}}, exp_a[r*N*WAB +: N*WAB]};
    for (int k = 0; k < K; k++) beats[M+k]   = {{(RW-N*WAB){1'b1}}, exp_b[k*N*WAB +: N*WAB]};
    for (int r = 0; r < M; r++) beats[M+K+r] = RW'(exp_c[r*K*WC +: K*WC]);
  endtask

  task automatic check_mats(input string tag);
    for (int r = 0; r < M; r++)
      check($sformatf("%s_a%0d", tag, r), RW'(a_o[r*N*WAB +: N*WAB]), RW'(exp_a[r*N*WAB +: N*WAB]));
    for (int k = 0; k < K; k++)
      check($sformatf("%s_b%0d", tag, k), RW'(b_o[k*N*WAB +: N*WAB]), RW'(exp_b[k*N*WAB +: N*WAB]));
    for (int r = 0; r < M; r++)
      check($sformatf("%s_c%0d", tag, r), RW'(c_o[r*K*WC +: K*WC]), RW'(exp_c[r*K*WC +: K*WC]));
  endtask

  // Drives n_beats accepted beats (cycling through the 24-beat table); gaps at gap_pct percent.
  task automatic drive(input int n_beats, input int gap_pct, input logic [2:0] t_rm,
                       input logic [7:0] t_idxw, input logic [DW-1:0] t_warp, output int first_cyc);
    int idx = 0;
    int guard = 0;
    logic acc;
    first_cyc = -1;
    while (idx < n_beats && guard < 4000) begin
      guard++;
      if (gap_pct > 0 && $urandom_range(0, 99) < gap_pct) begin
        row_valid_i = 1'b0;
      end else begin
        row_valid_i = 1'b1;
        row_data_i  = beats[idx % NB];
      end
      if ((idx % NB) == 0) begin
        rm_i = t_rm; ctrl_reg_idxw_i = t_idxw; ctrl_warpid_i = t_warp;
      end else begin
        rm_i = ~t_rm; ctrl_reg_idxw_i = ~t_idxw; ctrl_warpid_i = ~t_warp;
      end
      acc = row_valid_i && row_ready_o;
      if (acc && idx == 0) first_cyc = cyc;
      @(posedge clk); #1;
      if (acc) idx++;
    end
    row_valid_i = 1'b0;
    check("drive_done", RW'(idx), RW'(n_beats));
  endtask

  task automatic post_issue(input string tag, input logic [2:0] t_rm, input logic [7:0] t_idxw,
                            input logic [DW-1:0] t_warp, input int first_cyc, input bit chk_lat);
    @(negedge clk); #1;
    check({tag, "_valid"}, RW'(out_valid_o), RW'(1));
    check({tag, "_rdy"}, RW'(row_ready_o), RW'(0));
    if (chk_lat) check({tag, "_latency"}, RW'(last_rise() - first_cyc), RW'(24));
    check_mats(tag);
    check({tag, "_rm"}, RW'(rm_o), RW'(t_rm));
    check({tag, "_idxw"}, RW'(ctrl_reg_idxw_o), RW'(t_idxw));
    check({tag, "_warp"}, RW'(ctrl_warpid_o), RW'(t_warp));
  endtask

  initial begin
    rst_n = 1'b0; row_valid_i = 1'b0; row_data_i = '0; rm_i = 3'd0; ctrl_reg_idxw_i = 8'd0;
    ctrl_warpid_i = 4'd0; flush_i = 1'b0; out_ready_i = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_valid", RW'(out_valid_o), RW'(0));
    check("rst_ready", RW'(row_ready_o), RW'(1));
    check("rst_a", RW'(a_o[N*WAB-1:0]), RW'(0));
    check("rst_c", RW'(c_o[M*K*WC-1 -: K*WC]), RW'(0));
    check("rst_ctrl", RW'({rm_o, ctrl_reg_idxw_o, ctrl_warpid_o}), RW'(0));
    @(posedge clk); #1 rst_n = 1'b1;
    @(posedge clk); #1;

    // Single transaction, flat-index data, ready held high.
    out_ready_i = 1'b1; build(0); rises.delete();
    drive(NB, 0, 3'd5, 8'h3C, 4'hA, first);
    post_issue("t1", 3'd5, 8'h3C, 4'hA, first, 1'b1);
    @(posedge clk); #1;
    check("t1_done_valid", RW'(out_valid_o), RW'(0));
    check("t1_done_ready", RW'(row_ready_o), RW'(1));

    // Issue held five cycles; a beat presented meanwhile must not be taken.
    out_ready_i = 1'b0; build(100); rises.delete();
    drive(NB, 0, 3'd2, 8'h81, 4'h6, first);
    post_issue("t2", 3'd2, 8'h81, 4'h6, first, 1'b1);
    row_valid_i = 1'b1; row_data_i = '1;
    for (int i = 0; i < 5; i++) begin
      check($sformatf("t2_hold%0d_valid", i), RW'(out_valid_o), RW'(1));
      check($sformatf("t2_hold%0d_ready", i), RW'(row_ready_o), RW'(0));
      check_mats($sformatf("t2_hold%0d", i));
      @(posedge clk); #1;
    end
    out_ready_i = 1'b1;
    @(posedge clk); #1;
    row_valid_i = 1'b0;
    check("t2_done_valid", RW'(out_valid_o), RW'(0));
    check("t2_done_ready", RW'(row_ready_o), RW'(1));

    // Flush on B beat 3, then a fresh transaction.
    build(200);
    drive(M + 3, 0, 3'd1, 8'h11, 4'h1, first);
    flush_i = 1'b1; row_valid_i = 1'b1; row_data_i = beats[M+3];
    check("t3_flush_ready", RW'(row_ready_o), RW'(1));
    @(posedge clk); #1;
    flush_i = 1'b0; row_valid_i = 1'b0;
    check("t3_flush_valid", RW'(out_valid_o), RW'(0));
    build(300); rises.delete();
    drive(NB, 0, 3'd7, 8'hC3, 4'h5, first);
    post_issue("t3", 3'd7, 8'hC3, 4'h5, first, 1'b1);
    @(posedge clk); #1;

    // Valid gaps must not change the result of the flat-index run.
    build(0); rises.delete();
    drive(NB, 30, 3'd5, 8'h3C, 4'hA, first);
    post_issue("t4", 3'd5, 8'h3C, 4'hA, first, 1'b0);
    @(posedge clk); #1;

    // Reset after ten beats, then a clean transaction.
    build(400);
    drive(10, 0, 3'd3, 8'h44, 4'h4, first);
    #2 rst_n = 1'b0;
    #1;
    check("t5_rst_valid", RW'(out_valid_o), RW'(0));
    check("t5_rst_ready", RW'(row_ready_o), RW'(1));
    check("t5_rst_a", RW'(a_o[N*WAB-1:0]), RW'(0));
    @(posedge clk); #1 rst_n = 1'b1;
    @(posedge clk); #1;
    build(500); rises.delete();
    drive(NB, 0, 3'd6, 8'h5A, 4'h9, first);
    post_issue("t5", 3'd6, 8'h5A, 4'h9, first, 1'b1);
    @(posedge clk); #1;

    // Reset during issue drops valid without waiting for a clock.
    out_ready_i = 1'b0; build(600);
    drive(NB, 0, 3'd0, 8'h66, 4'h3, first);
    check("t6_issue_valid", RW'(out_valid_o), RW'(1));
    #2 rst_n = 1'b0;
    #1;
    check("t6_async_valid", RW'(out_valid_o), RW'(0));
    check("t6_async_ready", RW'(row_ready_o), RW'(1));
    @(posedge clk); #1 rst_n = 1'b1; out_ready_i = 1'b1;
    @(posedge clk); #1;

    // Back-to-back: three transactions with valid always high.
    build(700); rises.delete();
    drive(3 * NB, 0, 3'd4, 8'h77, 4'hC, first);
    post_issue("t7", 3'd4, 8'h77, 4'hC, first, 1'b0);
    check("t7_issue_count", RW'(rises.size()), RW'(3));
    if (rises.size() >= 3) begin
      check("t7_first_latency", RW'(rises[0] - first), RW'(24));
      check("t7_period0", RW'(rises[1] - rises[0]), RW'(25));
      check("t7_period1", RW'(rises[2] - rises[1]), RW'(25));
    end
    @(posedge clk); #1;
    check("t7_done_valid", RW'(out_valid_o), RW'(0));

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
